neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/nn_pkg.sv | 14 +
 rtl/neuron_mac_if.sv | 28 ++
 rtl/nn_mult8.sv | 12 +
 rtl/neuron_mac.sv | 76 +++++++
 tb/tb_neuron_mac.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types and widths for the neuron datapath blocks.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NN_WIDTH = 32;
    localparam int ACT_W    = 8;
    localparam int PROD_W   = 2 * ACT_W;

endpackage

// File: rtl/neuron_mac_if.sv
// Start/beat/result handshake bundle between a neuron_mac and its producer/consumer.
interface neuron_mac_if
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH
);
    logic                     start;
    logic signed [WIDTH-1:0]  bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ACT_W-1:0]  x_in;
    logic signed [ACT_W-1:0]  w_in;
    logic                     res_ack;
    logic signed [WIDTH-1:0]  a_out;
    logic                     ready_signal;
    logic                     busy;

    modport master (
        output start, bias, in_valid, x_in, w_in, res_ack,
        input  in_ready, a_out, ready_signal, busy
    );

    modport slave (
        input  start, bias, in_valid, x_in, w_in, res_ack,
        output in_ready, a_out, ready_signal, busy
    );

endinterface

// File: rtl/nn_mult8.sv
// Signed 8x8 -> 16 combinational multiply for one activation/weight beat.
module nn_mult8
    import nn_pkg::*;
(
    input  logic signed [ACT_W-1:0]  i_a,
    input  logic signed [ACT_W-1:0]  i_b,
    output logic signed [PROD_W-1:0] o_p
);

    assign o_p = i_a * i_b;

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: bias + sum of N_INPUTS x*w beats, wrapping at WIDTH bits.
//
// state    | meaning
// ST_IDLE  | waiting for start; acc holds the last result
// ST_ACCUM | accepting x/w beats until N_INPUTS have been summed
// ST_DONE  | a_out final, ready_signal high until res_ack
module neuron_mac
    import nn_pkg::*;
#(
    parameter int WIDTH    = NN_WIDTH,
    parameter int N_INPUTS = 64,
    parameter int CNT_W    = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    neuron_mac_if.slave   bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [WIDTH-1:0]  w_prod_ext;
    logic                     w_beat;
    logic                     w_last;

    nn_mult8 u_mult (
        .i_a (bus.x_in),
        .i_b (bus.w_in),
        .o_p (w_prod)
    );

    assign w_prod_ext = WIDTH'(w_prod);
    assign w_beat     = (r_state == ST_ACCUM) && bus.in_valid;
    assign w_last     = (r_cnt == CNT_W'(N_INPUTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start)         w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_beat && w_last)  w_state_nxt = ST_DONE;
            ST_DONE:  if (bus.res_ack)       w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Accumulator and beat counter move only on start-in-IDLE or an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_acc <= bus.bias;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready     = (r_state == ST_ACCUM);
    assign bus.ready_signal = (r_state == ST_DONE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.a_out        = r_acc;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: vector table with scoreboard plus corner sequences.
module tb_neuron_mac;

    logic clk;
    logic rst_n;

    neuron_mac_if #(.WIDTH(32)) bus4 ();
    neuron_mac_if #(.WIDTH(32)) bus1 ();

    neuron_mac #(.WIDTH(32), .N_INPUTS(4), .CNT_W(16)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    neuron_mac #(.WIDTH(32), .N_INPUTS(1), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        int          bias;
        int          x[4];
        int          w[4];
        int          gap[4];
        logic [31:0] exp;
    } vec_t;

    localparam int N_VEC = 6;
    vec_t        vecs[N_VEC];
    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic wait_ready4(input string nm);
        int t;
        t = 0;
        while (!bus4.ready_signal && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_latency"}, 32'(t), 32'd0);
    endtask

    task automatic finish_ack4(input string nm, input logic [31:0] exp);
        @(negedge clk);
        chk({nm, "_hold_ready"}, 32'(bus4.ready_signal), 32'd1);
        chk({nm, "_hold_aout"}, bus4.a_out, exp);
        chk({nm, "_done_inrdy"}, 32'(bus4.in_ready), 32'd0);
        bus4.res_ack = 1'b1;
        @(negedge clk);
        bus4.res_ack = 1'b0;
        chk({nm, "_idle_busy"}, 32'(bus4.busy), 32'd0);
        chk({nm, "_idle_ready"}, 32'(bus4.ready_signal), 32'd0);
    endtask

    task automatic run4(input vec_t v, input string nm);
        logic [31:0] e;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.bias  = v.bias;
        exp_q.push_back(v.exp);
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.bias  = 32'h5555_5555;
        chk({nm, "_accum_busy"}, 32'(bus4.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b0;
            bus4.x_in     = 8'sh7F;
            bus4.w_in     = 8'sh7F;
            repeat (v.gap[i]) @(negedge clk);
            chk({nm, "_inrdy"}, 32'(bus4.in_ready), 32'd1);
            bus4.in_valid = 1'b1;
            bus4.x_in     = 8'(v.x[i]);
            bus4.w_in     = 8'(v.w[i]);
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        wait_ready4(nm);
        e = exp_q.pop_front();
        chk({nm, "_aout"}, bus4.a_out, e);
        finish_ack4(nm, e);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0].bias = 10;  vecs[0].x = '{1, 2, 3, 4};
        vecs[0].w = '{5, -6, 7, -8};     vecs[0].gap = '{0, 0, 0, 0}; vecs[0].exp = 32'hFFFF_FFF8;
        vecs[1].bias = 10;  vecs[1].x = '{1, 2, 3, 4};
        vecs[1].w = '{5, -6, 7, -8};     vecs[1].gap = '{0, 0, 2, 1}; vecs[1].exp = 32'hFFFF_FFF8;
        vecs[2].bias = 0;   vecs[2].x = '{127, 127, 127, 127};
        vecs[2].w = '{-128, -128, -128, -128}; vecs[2].gap = '{0, 0, 0, 0}; vecs[2].exp = 32'hFFFF_0200;
        vecs[3].bias = 0;   vecs[3].x = '{-128, -128, -128, -128};
        vecs[3].w = '{-128, -128, -128, -128}; vecs[3].gap = '{0, 0, 0, 0}; vecs[3].exp = 32'h0001_0000;
        vecs[4].bias = -100; vecs[4].x = '{-1, -2, 10, 0};
        vecs[4].w = '{3, -4, 5, 9};      vecs[4].gap = '{1, 0, 3, 0}; vecs[4].exp = 32'hFFFF_FFD3;
        vecs[5].bias = 32'h7FFF_FFFF; vecs[5].x = '{1, 1, 1, 1};
        vecs[5].w = '{1, 1, 1, 1};       vecs[5].gap = '{0, 0, 0, 0}; vecs[5].exp = 32'h8000_0003;

        rst_n = 1'b0;
        bus4.start = 1'b0; bus4.bias = '0; bus4.in_valid = 1'b0;
        bus4.x_in = '0; bus4.w_in = '0; bus4.res_ack = 1'b0;
        bus1.start = 1'b0; bus1.bias = '0; bus1.in_valid = 1'b0;
        bus1.x_in = '0; bus1.w_in = '0; bus1.res_ack = 1'b0;

        #12;
        chk("rst_aout", bus4.a_out, 32'd0);
        chk("rst_ready", 32'(bus4.ready_signal), 32'd0);
        chk("rst_inrdy", 32'(bus4.in_ready), 32'd0);
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_busy1", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < N_VEC; k++) begin
            run4(vecs[k], $sformatf("vec%0d", k));
        end

        // In IDLE, beats must be ignored and the last result held.
        bus4.in_valid = 1'b1;
        bus4.x_in = 8'sd5;
        bus4.w_in = 8'sd5;
        repeat (3) @(negedge clk);
        chk("idle_valid_aout", bus4.a_out, vecs[N_VEC-1].exp);
        chk("idle_valid_inrdy", 32'(bus4.in_ready), 32'd0);
        bus4.in_valid = 1'b0;

        // start during ACCUM and res_ack outside DONE are ignored; start+res_ack in DONE only returns to IDLE.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.bias  = 10;
        exp_q.push_back(32'hFFFF_FFF8);
        @(negedge clk);
        bus4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.x_in     = 8'(vecs[0].x[i]);
            bus4.w_in     = 8'(vecs[0].w[i]);
            bus4.res_ack  = (i == 1);
            @(negedge clk);
            bus4.res_ack  = 1'b0;
            if (i == 1) begin
                bus4.in_valid = 1'b0;
                bus4.start    = 1'b1;
                bus4.bias     = 32'd999;
                @(negedge clk);
                bus4.start    = 1'b0;
            end
        end
        bus4.in_valid = 1'b0;
        wait_ready4("ign");
        chk("ign_aout", bus4.a_out, exp_q.pop_front());
        bus4.start   = 1'b1;
        bus4.res_ack = 1'b1;
        @(negedge clk);
        bus4.start   = 1'b0;
        bus4.res_ack = 1'b0;
        chk("ign_both_busy", 32'(bus4.busy), 32'd0);
        chk("ign_both_inrdy", 32'(bus4.in_ready), 32'd0);
        chk("ign_both_ready", 32'(bus4.ready_signal), 32'd0);
        @(negedge clk);
        chk("ign_stay_idle", 32'(bus4.busy), 32'd0);
        run4(vecs[0], "after_ign");

        // Asynchronous reset mid-ACCUM discards the partial sum.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.bias  = 10;
        @(negedge clk);
        bus4.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.in_valid = 1'b1;
            bus4.x_in     = 8'(vecs[0].x[i]);
            bus4.w_in     = 8'(vecs[0].w[i]);
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_aout", bus4.a_out, 32'd0);
        chk("arst_inrdy", 32'(bus4.in_ready), 32'd0);
        chk("arst_busy", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run4(vecs[0], "after_rst");

        // Single-beat configuration.
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.bias  = -3;
        @(negedge clk);
        bus1.start    = 1'b0;
        chk("n1_inrdy", 32'(bus1.in_ready), 32'd1);
        bus1.in_valid = 1'b1;
        bus1.x_in     = 8'sd2;
        bus1.w_in     = 8'sd2;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("n1_ready", 32'(bus1.ready_signal), 32'd1);
        chk("n1_aout", bus1.a_out, 32'd1);
        chk("n1_inrdy_done", 32'(bus1.in_ready), 32'd0);
        bus1.res_ack = 1'b1;
        @(negedge clk);
        bus1.res_ack = 1'b0;
        chk("n1_idle", 32'(bus1.busy), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
